freq_meter_400hz: RTL and testbench
===================================

Name: freq_meter_400hz

Overview:
- Receive-side counterpart of the team's 400 Hz square-wave generator.
- Samples an external square wave and measures its period and high time in system-clock cycles.
- Flags whether the measured period is within tolerance of the expected 400 Hz count, and detects loss of signal.
- Sits on the input side of the board, e.g. loop-back checking of the generator output or monitoring an external tone source.

Parameters:
- W, 32, width of the cycle counter and the measurement outputs.
- EXPECTED_PERIOD, 67500, nominal period in clk cycles (27 MHz / 400 Hz).
- TOLERANCE, 675, maximum allowed |period - EXPECTED_PERIOD| for in_range=1 (1%).
- TIMEOUT, 135000, cycles without a rising edge before loss of signal is declared; must be < 2^W - 1.

Ports:
- clk  input  1  system clock; the single clock for the block.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous square wave to be measured.
- period  output  W  cycles between the last two detected rising edges.
- high_time  output  W  cycles from a rising edge to the following falling edge, for the same period.
- meas_valid  output  1  one-cycle pulse when period, high_time and in_range update.
- in_range  output  1  period is within EXPECTED_PERIOD +/- TOLERANCE.
- timeout  output  1  sticky loss-of-signal flag.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- rst=1 forces all registers to 0, including period, high_time, meas_valid, in_range, timeout, the counter and the synchroniser. State goes to IDLE. Reset mid-measurement discards the partial count.

Input path:
- sig_in passes through a 2-flop synchroniser s1 -> s2, then a history flop s3.
- rise = s2 & ~s3; fall = ~s2 & s3.
- Edge detection latency is 3 clk edges after sig_in changes.

State machine:
- IDLE: cnt held at 0. On rise, go to MEASURE with cnt <= 1. No meas_valid is produced by this first edge.
- MEASURE: cnt <= cnt + 1 each cycle.
- On fall in MEASURE: hi_lat <= cnt. Internal only.
- On rise in MEASURE:
  - period <= cnt and high_time <= hi_lat.
  - in_range <= (|cnt - EXPECTED_PERIOD| <= TOLERANCE), computed in W+1-bit signed arithmetic.
  - meas_valid <= 1 for exactly one cycle; timeout <= 0; cnt <= 1.
  - All of these outputs change on the same clk edge.
- MEASURE, when cnt == TIMEOUT and there is no rise this cycle: go to IDLE, cnt <= 0, timeout <= 1.
  - period, high_time and in_range hold their last values.
- rise and cnt == TIMEOUT in the same cycle: the rise wins and is processed as a normal measurement.

Counting and output rules:
- Counting convention: a square wave of P cycles per period yields period=P. Rise after H high cycles yields high_time=H.
- The counter never wraps, because TIMEOUT bounds it.
- timeout clears only on a valid measurement or on rst. After a timeout, two rising edges are needed before the next meas_valid.
- meas_valid is 0 in every cycle other than the update cycle.

Test Plan:
- Reset, then sig_in with 67500-cycle period and 33750 high -> from the second rise onward: period=67500, high_time=33750, in_range=1, meas_valid pulses once per period, timeout=0.
- Period 68175 (EXPECTED+675) -> in_range=1. Period 68176 -> in_range=0. Period 66825 -> in_range=1. Period 66824 -> in_range=0.
- 25% duty: period 100, high 25 -> period=100, high_time=25, in_range=0.
- Hold sig_in low after valid measurements -> timeout=1 exactly TIMEOUT cycles after the last rise count started, and period holds its prior value. Restart the toggling -> no meas_valid on the first rise; valid on the second, with timeout cleared.
- Assert rst mid-period -> all outputs 0 immediately, without waiting for a clk edge. After release, the first rise produces no meas_valid, and the next full period measures correctly.
- Rise landing on the same cycle as cnt == TIMEOUT (period = TIMEOUT) -> meas_valid=1, period=135000, timeout stays 0.

Source files
------------

// File: rtl/freq_meter_400hz.sv
// Measures period and high time of an external square wave in clk cycles,
// flags the period against a 400 Hz window and detects loss of signal.
//
// state   | meaning
// IDLE    | waiting for the first rising edge, cnt held at 0
// MEASURE | counting cycles since the last rising edge
module freq_meter_400hz #(
  parameter int W               = 32,
  parameter int EXPECTED_PERIOD = 67500,
  parameter int TOLERANCE       = 675,
  parameter int TIMEOUT         = 135000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         meas_valid,
  output logic         in_range,
  output logic         timeout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic signed [W:0] EXP_S = (W+1)'(EXPECTED_PERIOD);
  localparam logic signed [W:0] TOL_S = (W+1)'(TOLERANCE);
  localparam logic [W-1:0]      TO_CNT = W'(TIMEOUT);

  state_t         state;
  logic           s1, s2, s3;
  logic [W-1:0]   cnt;
  logic [W-1:0]   hi_lat;
  logic           rise, fall;
  logic signed [W:0] diff, mag;
  logic           in_tol;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Signed W+1-bit distance from nominal so cnt below EXPECTED_PERIOD cannot wrap.
  always_comb begin
    diff   = $signed({1'b0, cnt}) - EXP_S;
    mag    = (diff < 0) ? -diff : diff;
    in_tol = (mag <= TOL_S);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state <= MEASURE;
            cnt   <= W'(1);
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle still counts as a good measurement.
          if (rise) begin
            period     <= cnt;
            high_time  <= hi_lat;
            in_range   <= in_tol;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            cnt        <= W'(1);
          end else if (cnt == TO_CNT) begin
            state   <= IDLE;
            cnt     <= '0;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + W'(1);
            if (fall) hi_lat <= cnt;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_400hz.sv
// Directed bench for freq_meter_400hz with scaled parameters so the run stays short.
module tb_freq_meter_400hz;

  localparam int W    = 16;
  localparam int EXP  = 200;
  localparam int TOL  = 10;
  localparam int TOUT = 400;

  logic         clk;
  logic         rst;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         in_range;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  int gen_per = 200;
  int gen_hi  = 100;
  bit gen_en  = 1'b0;

  freq_meter_400hz #(
    .W(W), .EXPECTED_PERIOD(EXP), .TOLERANCE(TOL), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period(period),
    .high_time(high_time), .meas_valid(meas_valid), .in_range(in_range),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square-wave source; each period reads the config at its edges.
  initial begin
    sig_in = 1'b0;
    forever begin
      if (gen_en) begin
        sig_in = 1'b1;
        repeat (gen_hi) @(negedge clk);
        sig_in = 1'b0;
        repeat (gen_per - gen_hi) @(negedge clk);
      end else begin
        sig_in = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!meas_valid && cyc < 2000);
    if (!meas_valid) check({tag, "_valid_to"}, 32'd0, 32'd1);
  endtask

  // Discard one update (config change period), check the next one.
  task automatic measure(input string tag, input int ep, input int eh, input bit er);
    int n;
    wait_valid({tag, "_skip"}, n);
    wait_valid(tag, n);
    check({tag, "_spacing"}, n, ep);
    check({tag, "_period"}, period, ep);
    check({tag, "_high"}, high_time, eh);
    check({tag, "_inrange"}, in_range, er);
    check({tag, "_tout"}, timeout, 0);
    @(negedge clk);
    check({tag, "_pulse"}, meas_valid, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_inrange", in_range, 0);
    check("rst_tout", timeout, 0);
    rst = 1'b0;
    gen_en = 1'b1;

    measure("nom", 200, 100, 1'b1);
    gen_per = 210; gen_hi = 105; measure("hi_edge", 210, 105, 1'b1);
    gen_per = 211; gen_hi = 105; measure("hi_out", 211, 105, 1'b0);
    gen_per = 190; gen_hi = 95;  measure("lo_edge", 190, 95, 1'b1);
    gen_per = 189; gen_hi = 94;  measure("lo_out", 189, 94, 1'b0);
    gen_per = 100; gen_hi = 25;  measure("duty25", 100, 25, 1'b0);

    // Loss of signal: source stops after the current period.
    wait_valid("los_sync", n);
    gen_en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout && n < 2 * TOUT);
    check("los_delay", n, TOUT);
    check("los_flag", timeout, 1);
    check("los_period", period, 100);
    check("los_high", high_time, 25);

    gen_per = 200; gen_hi = 100; gen_en = 1'b1;
    wait_valid("restart", n);
    check("restart_no_first", (n >= 200 && n <= 210), 1);
    check("restart_period", period, 200);
    check("restart_tout", timeout, 0);

    // Async reset mid-period, during the low phase.
    wait_valid("rst_sync", n);
    repeat (150) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_period", period, 0);
    check("arst_high", high_time, 0);
    check("arst_valid", meas_valid, 0);
    check("arst_inrange", in_range, 0);
    check("arst_tout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid("arst_rel", n);
    check("arst_first_skip", (n > 100), 1);
    check("arst_period2", period, 200);
    check("arst_high2", high_time, 100);
    check("arst_inrange2", in_range, 1);

    gen_per = 400; gen_hi = 200;
    measure("tout_edge", 400, 200, 1'b0);
    wait_valid("tout_edge2", n);
    check("tout_edge2_period", period, 400);
    check("tout_edge2_tout", timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
